// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-side arbiter and related schedulers.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  // Requester count always derives from the index width, so it stays a power of 2.
  function automatic int num_req(input int req_idx);
    return 1 << req_idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after prio_ptr,
// wrapping by natural REQ_IDX-bit overflow.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int REQ_IDX = 2
) (
  input  logic [num_req(REQ_IDX)-1:0] req,
  input  logic [REQ_IDX-1:0]          prio_ptr,
  output logic [REQ_IDX-1:0]          grant,
  output logic                        grant_any
);

  localparam int NUM_REQ = num_req(REQ_IDX);

  // Scanning from the farthest offset down lets the nearest request win last.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[prio_ptr + REQ_IDX'(i)]) begin
        grant     = prio_ptr + REQ_IDX'(i);
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO push port between
// NUM_REQ requesters, with a single registered output stage tagged by source.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int REQ_IDX = 2,
  parameter int SIZE    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [num_req(REQ_IDX)-1:0]      req_val,
  output logic [num_req(REQ_IDX)-1:0]      req_rdy,
  input  logic [num_req(REQ_IDX)*SIZE-1:0] req_data,
  input  logic [num_req(REQ_IDX)-1:0]      req_last,
  output logic                             out_val,
  input  logic                             out_rdy,
  output logic [SIZE-1:0]                  out_data,
  output logic [REQ_IDX-1:0]               out_src,
  output logic                             out_last
);

  localparam int NUM_REQ = num_req(REQ_IDX);

  arb_state_e         state_q, state_d;
  logic [REQ_IDX-1:0] prio_ptr_q, prio_ptr_d;
  logic [REQ_IDX-1:0] owner_q, owner_d;

  logic [REQ_IDX-1:0] pick_grant;
  logic               pick_any;
  logic [REQ_IDX-1:0] grant;
  logic               grant_valid;
  logic               load_en;
  logic               accept;
  logic [SIZE-1:0]    sel_data;
  logic               sel_last;

  rr_pick #(
    .REQ_IDX(REQ_IDX)
  ) u_rr_pick (
    .req       (req_val),
    .prio_ptr  (prio_ptr_q),
    .grant     (pick_grant),
    .grant_any (pick_any)
  );

  assign load_en     = !out_val || out_rdy;
  assign grant       = (state_q == LOCKED) ? owner_q : pick_grant;
  assign grant_valid = (state_q == LOCKED) || pick_any;
  assign accept      = |req_rdy;
  assign sel_data    = req_data[int'(grant)*SIZE +: SIZE];
  assign sel_last    = req_last[grant];

  always_comb begin
    req_rdy = '0;
    if (load_en && grant_valid && req_val[grant]) begin
      req_rdy[grant] = 1'b1;
    end
  end

  // A last beat always reopens arbitration; a first non-last beat locks the winner in.
  always_comb begin
    state_d    = state_q;
    prio_ptr_d = prio_ptr_q;
    owner_d    = owner_q;
    if (accept) begin
      if (sel_last) begin
        state_d    = IDLE;
        prio_ptr_d = grant + REQ_IDX'(1);
      end else if (state_q == IDLE) begin
        state_d = LOCKED;
        owner_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_ptr_q <= '0;
      owner_q    <= '0;
    end else begin
      state_q    <= state_d;
      prio_ptr_q <= prio_ptr_d;
      owner_q    <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      out_src  <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      out_val  <= 1'b1;
      out_data <= sel_data;
      out_src  <= grant;
      out_last <= sel_last;
    end else if (out_val && out_rdy) begin
      out_val <= 1'b0;
    end
  end

  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_rdy));

  a_locked_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == LOCKED) |-> ((req_rdy & ~(NUM_REQ'(1) << owner_q)) == '0));

  a_out_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_val && !out_rdy) |=> (out_val && $stable(out_data) && $stable(out_src) && $stable(out_last)));

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin packet model.
module tb_fifo_push_arbiter;

  localparam int REQ_IDX = 2;
  localparam int SIZE    = 4;
  localparam int N       = 1 << REQ_IDX;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req_val;
  logic [N-1:0]         req_rdy;
  logic [N*SIZE-1:0]    req_data;
  logic [N-1:0]         req_last;
  logic                 out_val;
  logic                 out_rdy;
  logic [SIZE-1:0]      out_data;
  logic [REQ_IDX-1:0]   out_src;
  logic                 out_last;

  int checks;
  int failures;

  // Per-requester pending beats: {last, data}
  logic [SIZE:0] beat_mem [N][16];
  int            head [N];
  int            tail [N];

  // Behavioural model state
  bit            m_locked;
  int            m_owner;
  int            m_ptr;
  int            m_grant;
  bit            m_out_val;
  logic [SIZE-1:0] m_out_data;
  int            m_out_src;
  bit            m_out_last;
  logic [N-1:0]  exp_rdy;

  // Observations taken mid-cycle
  logic [N-1:0]       obs_rdy;
  logic               obs_val;
  logic [SIZE-1:0]    obs_data;
  logic [REQ_IDX-1:0] obs_src;
  logic               obs_last;

  fifo_push_arbiter #(
    .REQ_IDX(REQ_IDX),
    .SIZE   (SIZE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_data (req_data),
    .req_last (req_last),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_src  (out_src),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int r, input logic last, input logic [SIZE-1:0] d);
    beat_mem[r][tail[r]] = {last, d};
    tail[r] = tail[r] + 1;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      if (tail[i] > head[i]) begin
        req_val[i]               = 1'b1;
        req_last[i]              = beat_mem[i][head[i]][SIZE];
        req_data[i*SIZE +: SIZE] = beat_mem[i][head[i]][SIZE-1:0];
      end else begin
        req_val[i]               = 1'b0;
        req_last[i]              = 1'b0;
        req_data[i*SIZE +: SIZE] = '0;
      end
    end
  endtask

  task automatic model_reset();
    m_locked   = 0;
    m_owner    = 0;
    m_ptr      = 0;
    m_out_val  = 0;
    m_out_data = '0;
    m_out_src  = 0;
    m_out_last = 0;
  endtask

  // Who may push this cycle: the packet owner, else the first valid requester from the pointer on.
  task automatic model_eval();
    bit load_en;
    int idx;
    load_en = !m_out_val || out_rdy;
    m_grant = -1;
    if (m_locked) begin
      m_grant = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (req_val[idx] && m_grant < 0) m_grant = idx;
      end
    end
    exp_rdy = '0;
    if (load_en && m_grant >= 0 && req_val[m_grant]) exp_rdy[m_grant] = 1'b1;
  endtask

  task automatic model_clock();
    if (exp_rdy != '0) begin
      m_out_val  = 1;
      m_out_data = req_data[m_grant*SIZE +: SIZE];
      m_out_src  = m_grant;
      m_out_last = req_last[m_grant];
      if (req_last[m_grant]) begin
        m_locked = 0;
        m_ptr    = (m_grant + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_owner  = m_grant;
      end
    end else if (m_out_val && out_rdy) begin
      m_out_val = 0;
    end
  endtask

  // Drive the current beats, evaluate the model, and sample the DUT at the falling edge.
  task automatic tick();
    apply_inputs();
    model_eval();
    @(negedge clk);
    obs_rdy  = req_rdy;
    obs_val  = out_val;
    obs_data = out_data;
    obs_src  = out_src;
    obs_last = out_last;
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (obs_rdy[i] && tail[i] > head[i]) begin
        head[i] = head[i] + 1;
        if (head[i] == tail[i]) begin
          head[i] = 0;
          tail[i] = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    clear_queues();
    apply_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (obs_val !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_out_val t=%0d got=%b exp=0", t, obs_val);
      end
      checks++;
      if (obs_rdy !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL reset_req_rdy t=%0d got=%b exp=0000", t, obs_rdy);
      end
      checks++;
      if (obs_src !== 2'd0 || obs_last !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_src_last t=%0d got src=%0d last=%b exp src=0 last=0", t, obs_src, obs_last);
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [N-1:0] rdy_exp;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      push(i, 1'b1, SIZE'($urandom));
      push(i, 1'b1, SIZE'($urandom));
    end
    for (int t = 0; t < 9; t++) begin
      tick();
      rdy_exp = (t < 8) ? N'(1) << order[t] : '0;
      checks++;
      if (obs_rdy !== rdy_exp) begin
        failures++;
        $display("[TB] FAIL rr_req_rdy t=%0d got=%b exp=%b", t, obs_rdy, rdy_exp);
      end
      if (t >= 1) begin
        checks++;
        if (obs_val !== 1'b1 || obs_src !== REQ_IDX'(order[t-1])) begin
          failures++;
          $display("[TB] FAIL rr_out_src t=%0d got val=%b src=%0d exp val=1 src=%0d", t, obs_val, obs_src, order[t-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_packet_lock();
    int              order [5] = '{1, 1, 1, 2, 3};
    logic [SIZE-1:0] dexp [5];
    logic            lexp [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [N-1:0]    rdy_exp;
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) dexp[k] = SIZE'($urandom);
    push(1, 1'b0, dexp[0]);
    push(1, 1'b0, dexp[1]);
    push(1, 1'b1, dexp[2]);
    push(2, 1'b1, dexp[3]);
    push(3, 1'b1, dexp[4]);
    for (int t = 0; t < 6; t++) begin
      tick();
      rdy_exp = (t < 5) ? N'(1) << order[t] : '0;
      checks++;
      if (obs_rdy !== rdy_exp) begin
        failures++;
        $display("[TB] FAIL lock_req_rdy t=%0d got=%b exp=%b", t, obs_rdy, rdy_exp);
      end
      if (t >= 1) begin
        checks++;
        if (obs_val !== 1'b1 || obs_src !== REQ_IDX'(order[t-1]) ||
            obs_data !== dexp[t-1] || obs_last !== lexp[t-1]) begin
          failures++;
          $display("[TB] FAIL lock_out_beat t=%0d got val=%b src=%0d data=%h last=%b exp val=1 src=%0d data=%h last=%b",
                   t, obs_val, obs_src, obs_data, obs_last, order[t-1], dexp[t-1], lexp[t-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [SIZE-1:0] d0;
    logic [SIZE-1:0] d1;
    d0 = SIZE'($urandom);
    d1 = ~d0;
    out_rdy = 1'b1;
    push(0, 1'b1, d0);
    push(0, 1'b1, d1);
    tick();
    checks++;
    if (obs_rdy !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_first_accept got=%b exp=0001", obs_rdy);
    end
    advance();
    out_rdy = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (obs_rdy !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL bp_req_rdy t=%0d got=%b exp=0000", t, obs_rdy);
      end
      checks++;
      if (obs_val !== 1'b1 || obs_data !== d0 || obs_src !== 2'd0 || obs_last !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_hold t=%0d got val=%b data=%h src=%0d last=%b exp val=1 data=%h src=0 last=1",
                 t, obs_val, obs_data, obs_src, obs_last, d0);
      end
      advance();
    end
    out_rdy = 1'b1;
    tick();
    checks++;
    if (obs_rdy !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL bp_resume_accept got=%b exp=0001", obs_rdy);
    end
    advance();
    tick();
    checks++;
    if (obs_val !== 1'b1 || obs_data !== d1) begin
      failures++;
      $display("[TB] FAIL bp_second_beat got val=%b data=%h exp val=1 data=%h", obs_val, obs_data, d1);
    end
    advance();
  endtask

  task automatic test_wrap();
    out_rdy = 1'b1;
    push(3, 1'b1, SIZE'($urandom));
    tick();
    checks++;
    if (obs_rdy !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL wrap_req3 got=%b exp=1000", obs_rdy);
    end
    advance();
    push(0, 1'b1, SIZE'($urandom));
    push(3, 1'b1, SIZE'($urandom));
    tick();
    checks++;
    if (obs_rdy !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL wrap_to_0 got=%b exp=0001", obs_rdy);
    end
    advance();
    tick();
    checks++;
    if (obs_rdy !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL wrap_then_3 got=%b exp=1000", obs_rdy);
    end
    advance();
    tick();
    advance();
  endtask

  task automatic test_reset_mid_packet();
    out_rdy = 1'b1;
    push(0, 1'b1, SIZE'($urandom));
    tick();
    advance();
    push(2, 1'b0, SIZE'($urandom));
    push(2, 1'b0, SIZE'($urandom));
    tick();
    checks++;
    if (obs_rdy !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL mid_first_beat got=%b exp=0100", obs_rdy);
    end
    advance();
    push(0, 1'b1, SIZE'($urandom));
    push(3, 1'b1, SIZE'($urandom));
    tick();
    checks++;
    if (obs_rdy !== 4'b0100 || obs_val !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_locked got rdy=%b val=%b exp rdy=0100 val=1", obs_rdy, obs_val);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_out_val got=%b exp=0", out_val);
    end
    clear_queues();
    apply_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(0, 1'b1, SIZE'($urandom));
    push(3, 1'b1, SIZE'($urandom));
    tick();
    checks++;
    if (obs_rdy !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL post_reset_lowest got=%b exp=0001", obs_rdy);
    end
    advance();
    tick();
    checks++;
    if (obs_rdy !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL post_reset_next got=%b exp=1000", obs_rdy);
    end
    advance();
  endtask

  task automatic test_random();
    rst_n = 1'b0;
    clear_queues();
    apply_inputs();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (tail[i] == head[i] && $urandom_range(2) == 0) begin
          push(i, 1'($urandom_range(1)), SIZE'($urandom));
        end
      end
      out_rdy = ($urandom_range(3) != 0);
      tick();
      checks++;
      if (obs_rdy !== exp_rdy) begin
        failures++;
        $display("[TB] FAIL rand_req_rdy t=%0d got=%b exp=%b", t, obs_rdy, exp_rdy);
      end
      checks++;
      if (obs_val !== m_out_val) begin
        failures++;
        $display("[TB] FAIL rand_out_val t=%0d got=%b exp=%b", t, obs_val, m_out_val);
      end
      if (m_out_val) begin
        checks++;
        if (obs_data !== m_out_data || obs_src !== REQ_IDX'(m_out_src) || obs_last !== m_out_last) begin
          failures++;
          $display("[TB] FAIL rand_out_beat t=%0d got data=%h src=%0d last=%b exp data=%h src=%0d last=%b",
                   t, obs_data, obs_src, obs_last, m_out_data, m_out_src, m_out_last);
        end
      end
      advance();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    out_rdy  = 1'b1;
    req_val  = '0;
    req_last = '0;
    req_data = '0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_wrap();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
